axi4lite_apb_bridge: RTL

- AXI4-Lite slave to APB master bridge.
- Sits directly upstream of the APB latency-calibration stage and drives its `in_*` APB port.
- Converts one AXI4-Lite read or write at a time into a single APB SETUP/ACCESS transfer and returns the response on B or R.
- One outstanding transaction; no buffering beyond the captured request.

---
 rtl/axi4lite_apb_bridge_pkg.sv | 22 ++
 rtl/axi4lite_apb_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_apb_bridge_pkg.sv
// axi4lite_apb_bridge_pkg: shared state encoding and response codes for the AXI4-Lite to APB bridge.
// Rev 1.0
`default_nettype none

package axi4lite_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_BRESP  = 3'd3,
    ST_RRESP  = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

`default_nettype wire

// File: rtl/axi4lite_apb_bridge.sv
// axi4lite_apb_bridge: AXI4-Lite slave to APB master, one transfer at a time. Rev 1.0
// Optional ACCESS-phase timeout enabled by defining AXI4LITE_APB_BRIDGE_TIMEOUT_EN.
`default_nettype none

module axi4lite_apb_bridge
  import axi4lite_apb_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [2:0]          s_awprot,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [2:0]          s_arprot,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic [2:0]          pprot,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic                last_write_q, last_write_d;
  logic                awready_q, awready_d;
  logic                arready_q, arready_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                bvalid_q, bvalid_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic wr_elig;
  logic tmo_hit;

  assign wr_elig = s_awvalid && s_wvalid;

`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_write_d = last_write_q;
    awready_d    = 1'b0;
    arready_d    = 1'b0;
    paddr_d      = paddr_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pprot_d      = pprot_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A ready raised last cycle completes the handshake now; valids are held by the master.
        if (awready_q && wr_elig) begin
          paddr_d  = s_awaddr;
          pprot_d  = s_awprot;
          pwrite_d = 1'b1;
          pwdata_d = s_wdata;
          pstrb_d  = s_wstrb;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else if (arready_q && s_arvalid) begin
          paddr_d  = s_araddr;
          pprot_d  = s_arprot;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          pstrb_d  = '0;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready || tmo_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          resp_d    = (!pready || pslverr) ? RESP_SLVERR : RESP_OKAY;
          if (!pwrite_q) begin
            rdata_d = pready ? prdata : '0;
          end
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          state_d   = pwrite_q ? ST_BRESP : ST_RRESP;
        end else begin
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      ST_BRESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RRESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant whenever the next cycle is IDLE, so a request pending at the response
    // handshake is accepted in the very next cycle.
    if (state_d == ST_IDLE) begin
      if (wr_elig && (!s_arvalid || !last_write_q)) begin
        awready_d    = 1'b1;
        last_write_d = 1'b1;
      end else if (s_arvalid) begin
        arready_d    = 1'b1;
        last_write_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_write_q <= 1'b0;
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      resp_q       <= RESP_OKAY;
      rdata_q      <= '0;
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_write_q <= last_write_d;
      awready_q    <= awready_d;
      arready_q    <= arready_d;
      paddr_q      <= paddr_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pprot_q      <= pprot_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
`ifdef AXI4LITE_APB_BRIDGE_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = awready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = resp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pprot     = pprot_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

`default_nettype wire
